pc_fetch_ctrl: RTL and testbench
================================

// Module: pc_fetch_ctrl
// PURPOSE
//  Parametrised successor to the pipeline's bare PC register: generates the fetch
//  address for the IF stage with boot load, stall, branch redirect, post-redirect
//  flush bubbles and a small return-address stack (RAS). Sits between the pipeline
//  control inputs (pcSelect/startAddress, hazard, branch unit) and instruction memory.
// PARAMETERS
//  AW           32  address width (bits)
//  INCR          4  sequential increment (bytes), power of two
//  FLUSH_CYCLES  1  bubbles (pcValid=0) after redirect/ret, 0..7
//  RAS_DEPTH     4  return-address stack entries, power of two >=2
// PORTS
//  clk             in   1   rising-edge clock
//  reset           in   1   asynchronous, active-high
//  pcSelect        in   1   1 = load startAddress (boot/restart)
//  startAddress    in   AW  boot address
//  stall           in   1   hold pc (hazard)
//  redirect        in   1   branch/jump taken
//  redirectTarget  in   AW  target for redirect; fallback for ret on empty RAS
//  call            in   1   push linkAddr onto RAS
//  linkAddr        in   AW  return address to push
//  ret             in   1   pop RAS top and redirect to it
//  pc              out  AW  current fetch address
//  pcValid         out  1   pc is a real fetch (0 = bubble)
//  misaligned      out  1   pc[log2(INCR)-1:0] != 0 (combinational)
//  rasEmpty        out  1   RAS holds no entries
//  rasOverflow     out  1   sticky: push while full
//  rasUnderflow    out  1   sticky: ret while empty
// BEHAVIOUR
//  Reset (async, any time): pc=0, pcValid=0, state=IDLE, RAS count=0, rasEmpty=1,
//   sticky flags=0. Mid-operation reset discards pending flush and RAS contents.
//  States: IDLE, LOAD, RUN, FLUSH. Per-edge priority:
//   reset > pcSelect > ret > redirect > stall > increment.
//  pcSelect=1 (any state): pc<=startAddress, state LOAD, pcValid=0, sticky flags
//   cleared, RAS count=0. LOAD holds pc while pcSelect=1; first edge with pcSelect=0
//   -> RUN, pcValid=1 with pc=startAddress (first fetch = startAddress).
//  IDLE: pc and pcValid held at 0 until pcSelect.
//  RUN: stall=1 -> pc held, pcValid stays 1; else pc<=pc+INCR, modulo 2^AW (wraps).
//  redirect (RUN or FLUSH, ignores stall): pc<=redirectTarget; if FLUSH_CYCLES>0 ->
//   FLUSH with pcValid=0 for exactly FLUSH_CYCLES cycles, pc held, then RUN
//   (pcValid=1, pc=target); FLUSH_CYCLES=0 -> stay RUN, pcValid=1 next cycle.
//   Redirect during FLUSH restarts the flush counter.
//  ret: as redirect, target=RAS top, count-1. Empty RAS: target=redirectTarget,
//   rasUnderflow<=1, count stays 0.
//  call: push linkAddr at edge (RUN/FLUSH only, independent of stall). Full: overwrite
//   oldest entry (circular), count saturates at RAS_DEPTH, rasOverflow<=1.
//  call+ret same edge: pop then push -> top replaced, count unchanged; pc<=old top.
//  redirect/call/ret ignored in IDLE and LOAD.
//  Latency: all control inputs affect pc one edge later; no combinational in->pc path.
//  misaligned is not corrected; pc loads target/startAddress unmodified.
// STRUCTURE
//  Shared include pipeline_defs.vh: state encodings (IDLE=0,LOAD=1,RUN=2,FLUSH=3),
//   default AW/INCR localparams.
//  Sub-module ras_stack (params AW, RAS_DEPTH): circular push/pop, count,
//   empty/full; pc_fetch_ctrl holds FSM, pc register, flush counter, sticky flags.
// TESTING
//  1 reset, pcSelect=1 for 2 cycles w/ startAddress=0x100, then 0 -> pcValid=1,
//    pc sequence 0x100,0x104,0x108.
//  2 RUN at 0x108, stall=1 for 3 cycles -> pc holds 0x108, pcValid=1; release -> 0x10C.
//  3 redirect to 0x2000, FLUSH_CYCLES=2 -> next 2 cycles pc=0x2000, pcValid=0; then
//    pcValid=1 pc=0x2000, 0x2004.
//  4 RAS_DEPTH=4: push 0x10,0x20,0x30,0x40,0x50 -> rasOverflow=1; 4 rets -> pc
//    0x50,0x40,0x30,0x20; 5th ret -> pc=redirectTarget, rasUnderflow=1, rasEmpty=1.
//  5 pc=0xFFFFFFFC, no stall -> next pc=0x00000000; redirect to 0x3002 -> misaligned=1.
//  6 assert reset mid-FLUSH with 2 RAS entries -> pc=0, pcValid=0, rasEmpty=1
//    immediately (before next clk edge).

Source files
------------

// File: rtl/pc_fetch_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pc_fetch_ctrl_pkg
//   Shared definitions for the fetch-address generator: FSM state encodings
//   and default geometry.
//   State encodings are stored as plain logic constants so that they line up
//   with legacy tooling that decodes the 2-bit state value directly:
//     IDLE=0, LOAD=1, RUN=2, FLUSH=3
// ---------------------------------------------------------------------------
package pc_fetch_ctrl_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_FLUSH = 2'd3;

  // Default address geometry.
  localparam int DEF_AW   = 32;
  localparam int DEF_INCR = 4;

  // Width of the flush bubble counter (FLUSH_CYCLES is limited to 0..7).
  localparam int FLUSH_CW = 3;

endpackage

// File: rtl/pc_fetch_ctrl_ras_stack.sv
// ---------------------------------------------------------------------------
// ras_stack
//   Circular return-address stack. A push while full overwrites the oldest
//   entry (the write pointer simply wraps), and the count saturates at
//   RAS_DEPTH. A simultaneous push and pop replaces the top entry in place.
//   The top entry is read combinationally so a return can redirect on the
//   same edge it is requested.
// Ports
//   clk        in   1          rising-edge clock
//   reset      in   1          asynchronous, active-high
//   clear      in   1          synchronous flush of all entries (count -> 0)
//   push       in   1          write push_data as new top
//   pop        in   1          remove top (ignored when empty)
//   push_data  in   AW         value pushed
//   top        out  AW         current top entry (undefined when empty)
//   empty      out  1          no entries held
//   full       out  1          RAS_DEPTH entries held
// ---------------------------------------------------------------------------
module ras_stack
  import pc_fetch_ctrl_pkg::*;
#(
  parameter int AW        = DEF_AW,
  parameter int RAS_DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          push,
  input  logic          pop,
  input  logic [AW-1:0] push_data,
  output logic [AW-1:0] top,
  output logic          empty,
  output logic          full
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(RAS_DEPTH);

  logic [AW-1:0] mem [RAS_DEPTH];
  logic [PW-1:0] wp_reg;      // next free slot; top lives at wp_reg-1
  logic [PW:0]   count_reg;
  logic [PW-1:0] top_idx;
  logic          pop_ok;

  assign top_idx = wp_reg - 1'b1;
  assign empty   = (count_reg == '0);
  assign full    = (count_reg == DEPTH_C);
  assign top     = mem[top_idx];
  assign pop_ok  = pop && !empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp_reg    <= '0;
      count_reg <= '0;
    end else if (clear) begin
      wp_reg    <= '0;
      count_reg <= '0;
    end else if (push && pop_ok) begin
      // Replace the top in place: pointer and count unchanged.
      wp_reg    <= wp_reg;
      count_reg <= count_reg;
    end else if (push) begin
      wp_reg    <= wp_reg + 1'b1;
      count_reg <= full ? count_reg : count_reg + 1'b1;
    end else if (pop_ok) begin
      wp_reg    <= top_idx;
      count_reg <= count_reg - 1'b1;
    end
  end

  // Entry storage carries no reset: validity is tracked entirely by count_reg.
  always_ff @(posedge clk) begin
    if (!clear && push) begin
      if (pop_ok) begin
        mem[top_idx] <= push_data;
      end else begin
        mem[wp_reg] <= push_data;
      end
    end
  end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// pc_fetch_ctrl
//   Fetch-address generator for the IF stage. Handles boot load, hazard
//   stall, branch redirect, post-redirect flush bubbles and call/return
//   prediction through a small return-address stack.
//   Per-edge priority: reset > pcSelect > ret > redirect > stall > increment.
//   All control inputs take effect one edge later; pc is purely registered.
// Ports
//   clk             in   1    rising-edge clock
//   reset           in   1    asynchronous, active-high
//   pcSelect        in   1    load startAddress (boot/restart)
//   startAddress    in   AW   boot address
//   stall           in   1    hold pc
//   redirect        in   1    branch/jump taken
//   redirectTarget  in   AW   redirect target; ret fallback on empty RAS
//   call            in   1    push linkAddr onto the RAS
//   linkAddr        in   AW   return address to push
//   ret             in   1    pop RAS top and redirect to it
//   pc              out  AW   current fetch address
//   pcValid         out  1    pc is a real fetch (0 = bubble)
//   misaligned      out  1    low address bits below INCR are non-zero
//   rasEmpty        out  1    RAS holds no entries
//   rasOverflow     out  1    sticky: push while full
//   rasUnderflow    out  1    sticky: ret while empty
// ---------------------------------------------------------------------------
module pc_fetch_ctrl
  import pc_fetch_ctrl_pkg::*;
#(
  parameter int AW           = DEF_AW,
  parameter int INCR         = DEF_INCR,
  parameter int FLUSH_CYCLES = 1,
  parameter int RAS_DEPTH    = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          pcSelect,
  input  logic [AW-1:0] startAddress,
  input  logic          stall,
  input  logic          redirect,
  input  logic [AW-1:0] redirectTarget,
  input  logic          call,
  input  logic [AW-1:0] linkAddr,
  input  logic          ret,
  output logic [AW-1:0] pc,
  output logic          pcValid,
  output logic          misaligned,
  output logic          rasEmpty,
  output logic          rasOverflow,
  output logic          rasUnderflow
);

  localparam int                  IB         = $clog2(INCR);
  localparam bit                  HAS_FLUSH  = (FLUSH_CYCLES > 0);
  localparam int                  FLUSH_LAST = HAS_FLUSH ? FLUSH_CYCLES - 1 : 0;
  localparam logic [FLUSH_CW-1:0] FLUSH_LOAD = FLUSH_CW'(FLUSH_LAST);
  localparam logic [AW-1:0]       INCR_C     = AW'(INCR);

  logic [1:0]          state_reg, state_next;
  logic [AW-1:0]       pc_reg, pc_next;
  logic                valid_reg, valid_next;
  logic [FLUSH_CW-1:0] flush_cnt_reg, flush_cnt_next;
  logic                ovf_reg, ovf_next;
  logic                unf_reg, unf_next;

  logic          active;
  logic          take_ret;
  logic          take_redirect;
  logic          ras_push;
  logic          ras_pop;
  logic [AW-1:0] ras_top;
  logic          ras_empty;
  logic          ras_full;
  logic [AW-1:0] target;

  // Control-flow inputs only matter once fetching has started, and pcSelect
  // pre-empts them entirely on the same edge.
  assign active        = !pcSelect && ((state_reg == ST_RUN) || (state_reg == ST_FLUSH));
  assign take_ret      = active && ret;
  assign take_redirect = active && (ret || redirect);
  assign ras_push      = active && call;
  assign ras_pop       = take_ret;

  // A return on an empty stack falls back to the branch unit's target.
  assign target = (take_ret && !ras_empty) ? ras_top : redirectTarget;

  ras_stack #(
    .AW        (AW),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .reset     (reset),
    .clear     (pcSelect),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (linkAddr),
    .top       (ras_top),
    .empty     (ras_empty),
    .full      (ras_full)
  );

  always_comb begin
    state_next     = state_reg;
    pc_next        = pc_reg;
    valid_next     = valid_reg;
    flush_cnt_next = flush_cnt_reg;
    ovf_next       = ovf_reg;
    unf_next       = unf_reg;

    if (pcSelect) begin
      state_next     = ST_LOAD;
      pc_next        = startAddress;
      valid_next     = 1'b0;
      flush_cnt_next = '0;
      ovf_next       = 1'b0;
      unf_next       = 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          valid_next = 1'b0;
        end
        ST_LOAD: begin
          // pc already holds startAddress; it becomes the first real fetch.
          state_next = ST_RUN;
          valid_next = 1'b1;
        end
        ST_RUN, ST_FLUSH: begin
          if (take_redirect) begin
            pc_next = target;
            if (HAS_FLUSH) begin
              state_next     = ST_FLUSH;
              valid_next     = 1'b0;
              flush_cnt_next = FLUSH_LOAD;
            end else begin
              state_next = ST_RUN;
              valid_next = 1'b1;
            end
          end else if (state_reg == ST_RUN) begin
            valid_next = 1'b1;
            if (!stall) begin
              pc_next = pc_reg + INCR_C;
            end
          end else begin
            // Bubble phase: pc parked on the target until the counter expires.
            if (flush_cnt_reg == '0) begin
              state_next = ST_RUN;
              valid_next = 1'b1;
            end else begin
              flush_cnt_next = flush_cnt_reg - 1'b1;
            end
          end

          if (take_ret && ras_empty) begin
            unf_next = 1'b1;
          end
          // A same-edge pop frees a slot, so call+ret never overflows.
          if (ras_push && ras_full && !ras_pop) begin
            ovf_next = 1'b1;
          end
        end
        default: begin
          state_next = ST_IDLE;
          valid_next = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      pc_reg        <= '0;
      valid_reg     <= 1'b0;
      flush_cnt_reg <= '0;
      ovf_reg       <= 1'b0;
      unf_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      pc_reg        <= pc_next;
      valid_reg     <= valid_next;
      flush_cnt_reg <= flush_cnt_next;
      ovf_reg       <= ovf_next;
      unf_reg       <= unf_next;
    end
  end

  assign pc           = pc_reg;
  assign pcValid      = valid_reg;
  assign rasEmpty     = ras_empty;
  assign rasOverflow  = ovf_reg;
  assign rasUnderflow = unf_reg;

  // Alignment is only reported, never corrected.
  generate
    if (IB > 0) begin : g_align
      assign misaligned = |pc_reg[IB-1:0];
    end else begin : g_no_align
      assign misaligned = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pc_fetch_ctrl
//   Directed stimulus with hand-computed expectations. Each stimulus cycle
//   queues the state expected after the next rising edge; a separate monitor
//   pops and compares one entry shortly after every rising edge.
// ---------------------------------------------------------------------------
module tb_pc_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pcSelect = 1'b0;
  logic [31:0] startAddress = '0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirectTarget = '0;
  logic        call = 1'b0;
  logic [31:0] linkAddr = '0;
  logic        ret = 1'b0;
  logic [31:0] pc;
  logic        pcValid;
  logic        misaligned;
  logic        rasEmpty;
  logic        rasOverflow;
  logic        rasUnderflow;

  always #5 clk = ~clk;

  pc_fetch_ctrl #(
    .AW           (32),
    .INCR         (4),
    .FLUSH_CYCLES (2),
    .RAS_DEPTH    (4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .pcSelect       (pcSelect),
    .startAddress   (startAddress),
    .stall          (stall),
    .redirect       (redirect),
    .redirectTarget (redirectTarget),
    .call           (call),
    .linkAddr       (linkAddr),
    .ret            (ret),
    .pc             (pc),
    .pcValid        (pcValid),
    .misaligned     (misaligned),
    .rasEmpty       (rasEmpty),
    .rasOverflow    (rasOverflow),
    .rasUnderflow   (rasUnderflow)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic        v;
    logic        emp;
    logic        ovf;
    logic        unf;
    logic        mis;
  } obs_t;

  obs_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    errors = 0;

  task automatic compare(input string nm, input obs_t e);
    obs_t a;
    a = '{pc: pc, v: pcValid, emp: rasEmpty, ovf: rasOverflow,
          unf: rasUnderflow, mis: misaligned};
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got pc=%h v=%b emp=%b ovf=%b unf=%b mis=%b, expected pc=%h v=%b emp=%b ovf=%b unf=%b mis=%b",
               nm, a.pc, a.v, a.emp, a.ovf, a.unf, a.mis,
               e.pc, e.v, e.emp, e.ovf, e.unf, e.mis);
    end else begin
      $display("ok   %s: pc=%h v=%b emp=%b ovf=%b unf=%b mis=%b",
               nm, a.pc, a.v, a.emp, a.ovf, a.unf, a.mis);
    end
  endtask

  // Monitor: one expectation per rising edge, sampled 1 time unit later.
  always @(posedge clk) begin : monitor
    obs_t  e;
    string n;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n = name_q.pop_front();
      compare(n, e);
    end
  end

  // Queue the expected post-edge state, then run one cycle (ends at negedge).
  task automatic tick(input string nm, input logic [31:0] p, input logic v,
                      input logic emp, input logic ovf, input logic unf,
                      input logic mis);
    exp_q.push_back('{pc: p, v: v, emp: emp, ovf: ovf, unf: unf, mis: mis});
    name_q.push_back(nm);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    obs_t rst_exp;
    @(negedge clk);
    tick("reset", 32'h0, 0, 1, 0, 0, 0);
    reset = 1'b0;
    tick("idle_hold", 32'h0, 0, 1, 0, 0, 0);

    // 1: boot load
    pcSelect = 1'b1; startAddress = 32'h100;
    tick("load_1", 32'h100, 0, 1, 0, 0, 0);
    tick("load_2", 32'h100, 0, 1, 0, 0, 0);
    pcSelect = 1'b0;
    tick("first_fetch", 32'h100, 1, 1, 0, 0, 0);
    tick("seq_104", 32'h104, 1, 1, 0, 0, 0);
    tick("seq_108", 32'h108, 1, 1, 0, 0, 0);

    // 2: stall
    stall = 1'b1;
    for (int i = 0; i < 3; i++) tick("stall_hold", 32'h108, 1, 1, 0, 0, 0);
    stall = 1'b0;
    tick("stall_release", 32'h10C, 1, 1, 0, 0, 0);

    // 3: redirect with two flush bubbles
    redirect = 1'b1; redirectTarget = 32'h2000;
    tick("redir_bubble1", 32'h2000, 0, 1, 0, 0, 0);
    redirect = 1'b0;
    tick("redir_bubble2", 32'h2000, 0, 1, 0, 0, 0);
    tick("redir_fetch", 32'h2000, 1, 1, 0, 0, 0);
    tick("redir_seq", 32'h2004, 1, 1, 0, 0, 0);

    // 4: RAS overflow then drain to underflow
    call = 1'b1;
    linkAddr = 32'h10; tick("call_10", 32'h2008, 1, 0, 0, 0, 0);
    linkAddr = 32'h20; tick("call_20", 32'h200C, 1, 0, 0, 0, 0);
    linkAddr = 32'h30; tick("call_30", 32'h2010, 1, 0, 0, 0, 0);
    linkAddr = 32'h40; tick("call_40", 32'h2014, 1, 0, 0, 0, 0);
    linkAddr = 32'h50; tick("call_50_ovf", 32'h2018, 1, 0, 1, 0, 0);
    call = 1'b0;
    ret = 1'b1; redirectTarget = 32'h7000;
    tick("ret_50", 32'h50, 0, 0, 1, 0, 0);
    tick("ret_40", 32'h40, 0, 0, 1, 0, 0);
    tick("ret_30", 32'h30, 0, 0, 1, 0, 0);
    tick("ret_20", 32'h20, 0, 1, 1, 0, 0);
    tick("ret_empty_unf", 32'h7000, 0, 1, 1, 1, 0);
    ret = 1'b0;
    tick("ret_bubble", 32'h7000, 0, 1, 1, 1, 0);
    tick("ret_fetch", 32'h7000, 1, 1, 1, 1, 0);
    tick("ret_seq", 32'h7004, 1, 1, 1, 1, 0);

    // 5: wrap-around and misalignment
    redirect = 1'b1; redirectTarget = 32'hFFFF_FFFC;
    tick("wrap_redir", 32'hFFFF_FFFC, 0, 1, 1, 1, 0);
    redirect = 1'b0;
    tick("wrap_bubble", 32'hFFFF_FFFC, 0, 1, 1, 1, 0);
    tick("wrap_fetch", 32'hFFFF_FFFC, 1, 1, 1, 1, 0);
    tick("wrap_zero", 32'h0, 1, 1, 1, 1, 0);
    redirect = 1'b1; redirectTarget = 32'h3002;
    tick("mis_redir", 32'h3002, 0, 1, 1, 1, 1);
    redirect = 1'b0;
    tick("mis_bubble", 32'h3002, 0, 1, 1, 1, 1);
    tick("mis_fetch", 32'h3002, 1, 1, 1, 1, 1);
    tick("mis_seq", 32'h3006, 1, 1, 1, 1, 1);

    // Restart clears sticky flags; then call+ret replaces the top entry.
    pcSelect = 1'b1; startAddress = 32'h400;
    tick("restart_load", 32'h400, 0, 1, 0, 0, 0);
    pcSelect = 1'b0;
    tick("restart_fetch", 32'h400, 1, 1, 0, 0, 0);
    call = 1'b1;
    linkAddr = 32'hA0; tick("call_a0", 32'h404, 1, 0, 0, 0, 0);
    linkAddr = 32'hB0; tick("call_b0", 32'h408, 1, 0, 0, 0, 0);
    linkAddr = 32'hC0; ret = 1'b1; redirectTarget = 32'h0;
    tick("call_ret_same", 32'hB0, 0, 0, 0, 0, 0);
    call = 1'b0; ret = 1'b0;
    tick("call_ret_bubble", 32'hB0, 0, 0, 0, 0, 0);
    ret = 1'b1;
    tick("ret_replaced_c0", 32'hC0, 0, 0, 0, 0, 0);
    ret = 1'b0; call = 1'b1; linkAddr = 32'hD0;
    tick("call_in_flush", 32'hC0, 0, 0, 0, 0, 0);
    call = 1'b0;

    // 6: asynchronous reset mid-flush with two RAS entries
    reset = 1'b1;
    #1;
    rst_exp = '{pc: 32'h0, v: 1'b0, emp: 1'b1, ovf: 1'b0, unf: 1'b0, mis: 1'b0};
    compare("async_reset", rst_exp);
    @(negedge clk);
    tick("reset_hold", 32'h0, 0, 1, 0, 0, 0);
    reset = 1'b0;
    redirect = 1'b1; ret = 1'b1; call = 1'b1; redirectTarget = 32'h5554;
    tick("idle_ignores_ctrl", 32'h0, 0, 1, 0, 0, 0);
    redirect = 1'b0; ret = 1'b0; call = 1'b0;

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
